// File: rtl/ram_arbiter.sv
// Shares one byte-lane data RAM between instruction fetch (read-only) and load/store.
// Optional macro RAM_RAW_BYPASS_EN merges a same-cycle LS store into the IF read data.
module ram_arbiter #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_req_addr,
    output logic          if_rsp_valid,
    input  logic          if_rsp_ready,
    output logic [DW-1:0] if_rsp_data,
    input  logic          ls_req_valid,
    output logic          ls_req_ready,
    input  logic          ls_req_we,
    input  logic [1:0]    ls_req_size,
    input  logic [AW-1:0] ls_req_addr,
    input  logic [DW-1:0] ls_req_wdata,
    output logic          ls_rsp_valid,
    input  logic          ls_rsp_ready,
    output logic [DW-1:0] ls_rsp_rdata,
    output logic          ls_rsp_err,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic          ram_ren,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
);

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_LIVE  = 2'd1,
        SLOT_HOLD  = 2'd2
    } slot_t;

    function automatic logic ls_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = off[0];
            2'd2:    bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_wen(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] wen;
        case (size)
            2'd0:    wen = 4'b0001 << off;
            2'd1:    wen = 4'b0011 << {off[1], 1'b0};
            2'd2:    wen = 4'b1111;
            default: wen = 4'b0000;
        endcase
        return wen;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'd0:    d = {4{wdata[7:0]}};
            2'd1:    d = {2{wdata[15:0]}};
            2'd2:    d = wdata;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] d;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    d = {24'h00_0000, sh[7:0]};
            2'd1:    d = {16'h0000, sh[15:0]};
            2'd2:    d = sh;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [3:0] wen,
                                               input logic [31:0] data);
        logic [31:0] d;
        d = old;
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) begin
                d[8*b +: 8] = data[8*b +: 8];
            end else begin
                d[8*b +: 8] = old[8*b +: 8];
            end
        end
        return d;
    endfunction

    slot_t          if_slot_r, if_slot_nxt_s;
    slot_t          ls_slot_r, ls_slot_nxt_s;
    logic           last_grant_if_r;
    logic [DW-1:0]  if_hold_data_r;
    logic [DW-1:0]  ls_hold_data_r;
    logic           ls_we_r;
    logic           ls_err_r;
    logic [1:0]     ls_size_r;
    logic [1:0]     ls_off_r;

    logic           if_drain_s, ls_drain_s;
    logic           if_elig_s, ls_elig_s;
    logic           ls_err_s, ls_load_s, ls_store_s;
    logic           conflict_s, grant_if_s;
    logic           if_acc_s, ls_acc_s;
    logic [DW-1:0]  if_live_data_s, ls_live_data_s;
    logic           unused_addr_bits_s;

    assign unused_addr_bits_s = ^if_req_addr[1:0];

    // Request classification, eligibility and round-robin arbitration of the read port
    always_comb begin
        ls_err_s     = ls_misaligned(ls_req_size, ls_req_addr[1:0]);
        ls_load_s    = !ls_req_we && !ls_err_s;
        ls_store_s   = ls_req_we && !ls_err_s;
        if_drain_s   = (if_slot_r != SLOT_EMPTY) && if_rsp_ready;
        ls_drain_s   = (ls_slot_r != SLOT_EMPTY) && ls_rsp_ready;
        if_elig_s    = if_req_valid && ((if_slot_r == SLOT_EMPTY) || if_drain_s);
        ls_elig_s    = ls_req_valid && ((ls_slot_r == SLOT_EMPTY) || ls_drain_s);
        conflict_s   = if_elig_s && ls_elig_s && ls_load_s;
        grant_if_s   = !last_grant_if_r;
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        if (rstn) begin
            if_req_ready = 1'b0;
            ls_req_ready = 1'b0;
        end else begin
            if_req_ready = if_elig_s && (!conflict_s || grant_if_s);
            ls_req_ready = ls_elig_s && (!conflict_s || !grant_if_s);
        end
        if_acc_s = if_req_valid && if_req_ready;
        ls_acc_s = ls_req_valid && ls_req_ready;
    end

    // RAM pin drive: store in the accept cycle, single read port shared by IF and LS loads
    always_comb begin
        ram_wen    = 4'h0;
        ram_w_addr = {AW{1'b0}};
        ram_w_data = {DW{1'b0}};
        ram_ren    = 1'b0;
        ram_r_addr = {AW{1'b0}};
        if (ls_acc_s && ls_store_s) begin
            ram_wen    = store_wen(ls_req_size, ls_req_addr[1:0]);
            ram_w_addr = {ls_req_addr[AW-1:2], 2'b00};
            ram_w_data = store_data(ls_req_size, ls_req_wdata);
        end else begin
            ram_wen = 4'h0;
        end
        if (if_acc_s) begin
            ram_ren    = 1'b1;
            ram_r_addr = {if_req_addr[AW-1:2], 2'b00};
        end else if (ls_acc_s && ls_load_s) begin
            ram_ren    = 1'b1;
            ram_r_addr = {ls_req_addr[AW-1:2], 2'b00};
        end else begin
            ram_ren = 1'b0;
        end
    end

`ifdef RAM_RAW_BYPASS_EN
    logic [3:0]    byp_wen_r;
    logic [DW-1:0] byp_data_r;

    // Remember bytes stored to the word IF reads in the same cycle
    always_ff @(posedge clk) begin
        if (rstn) begin
            byp_wen_r  <= 4'h0;
            byp_data_r <= {DW{1'b0}};
        end else if (if_acc_s && (ram_wen != 4'h0) &&
                     (ram_w_addr[AW-1:2] == ram_r_addr[AW-1:2])) begin
            byp_wen_r  <= ram_wen;
            byp_data_r <= ram_w_data;
        end else begin
            byp_wen_r  <= 4'h0;
        end
    end

    assign if_live_data_s = byte_merge(ram_r_data, byp_wen_r, byp_data_r);
`else
    assign if_live_data_s = byte_merge(ram_r_data, 4'h0, {DW{1'b0}});
`endif

    assign ls_live_data_s = (ls_we_r || ls_err_r) ? {DW{1'b0}}
                                                  : load_align(ram_r_data, ls_size_r, ls_off_r);

    // Response slot next-state for both ports
    always_comb begin
        if_slot_nxt_s = if_slot_r;
        ls_slot_nxt_s = ls_slot_r;
        case (if_slot_r)
            SLOT_EMPTY: if_slot_nxt_s = if_acc_s ? SLOT_LIVE : SLOT_EMPTY;
            SLOT_LIVE:  if_slot_nxt_s = !if_rsp_ready ? SLOT_HOLD :
                                        (if_acc_s ? SLOT_LIVE : SLOT_EMPTY);
            SLOT_HOLD:  if_slot_nxt_s = !if_rsp_ready ? SLOT_HOLD :
                                        (if_acc_s ? SLOT_LIVE : SLOT_EMPTY);
            default:    if_slot_nxt_s = SLOT_EMPTY;
        endcase
        case (ls_slot_r)
            SLOT_EMPTY: ls_slot_nxt_s = ls_acc_s ? SLOT_LIVE : SLOT_EMPTY;
            SLOT_LIVE:  ls_slot_nxt_s = !ls_rsp_ready ? SLOT_HOLD :
                                        (ls_acc_s ? SLOT_LIVE : SLOT_EMPTY);
            SLOT_HOLD:  ls_slot_nxt_s = !ls_rsp_ready ? SLOT_HOLD :
                                        (ls_acc_s ? SLOT_LIVE : SLOT_EMPTY);
            default:    ls_slot_nxt_s = SLOT_EMPTY;
        endcase
    end

    // Slot state, grant history, captured response data and LS request attributes
    always_ff @(posedge clk) begin
        if (rstn) begin
            if_slot_r       <= SLOT_EMPTY;
            ls_slot_r       <= SLOT_EMPTY;
            last_grant_if_r <= 1'b0;
            if_hold_data_r  <= {DW{1'b0}};
            ls_hold_data_r  <= {DW{1'b0}};
            ls_we_r         <= 1'b0;
            ls_err_r        <= 1'b0;
            ls_size_r       <= 2'd0;
            ls_off_r        <= 2'd0;
        end else begin
            if_slot_r <= if_slot_nxt_s;
            ls_slot_r <= ls_slot_nxt_s;
            if (conflict_s) begin
                last_grant_if_r <= grant_if_s;
            end
            if ((if_slot_r == SLOT_LIVE) && !if_rsp_ready) begin
                if_hold_data_r <= if_live_data_s;
            end
            if ((ls_slot_r == SLOT_LIVE) && !ls_rsp_ready) begin
                ls_hold_data_r <= ls_live_data_s;
            end
            if (ls_acc_s) begin
                ls_we_r   <= ls_req_we;
                ls_err_r  <= ls_err_s;
                ls_size_r <= ls_req_size;
                ls_off_r  <= ls_req_addr[1:0];
            end
        end
    end

    // Response outputs; valids forced low while reset is asserted
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_data  = {DW{1'b0}};
        ls_rsp_valid = 1'b0;
        ls_rsp_rdata = {DW{1'b0}};
        ls_rsp_err   = 1'b0;
        if (rstn) begin
            if_rsp_valid = 1'b0;
        end else begin
            case (if_slot_r)
                SLOT_LIVE: begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = if_live_data_s;
                end
                SLOT_HOLD: begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = if_hold_data_r;
                end
                default: if_rsp_valid = 1'b0;
            endcase
            case (ls_slot_r)
                SLOT_LIVE: begin
                    ls_rsp_valid = 1'b1;
                    ls_rsp_rdata = ls_live_data_s;
                    ls_rsp_err   = ls_err_r;
                end
                SLOT_HOLD: begin
                    ls_rsp_valid = 1'b1;
                    ls_rsp_rdata = ls_hold_data_r;
                    ls_rsp_err   = ls_err_r;
                end
                default: ls_rsp_valid = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural byte-lane RAM (registered read, old data on RAW).
module tb_ram_arbiter;
    logic        clk;
    logic        rstn;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid, ls_rsp_ready, ls_rsp_err;
    logic [1:0]  ls_req_size;
    logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_rdata;
    logic [3:0]  ram_wen;
    logic [31:0] ram_w_addr, ram_w_data, ram_r_addr, ram_r_data;
    logic        ram_ren;
    logic        tb_init;
    logic [31:0] mem [0:63];
    int          n_pass, n_fail, n_total;
    logic [31:0] exp_byp;

    ram_arbiter #(.DW(32), .AW(32)) dut (
        .clk(clk), .rstn(rstn),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
        .ls_req_size(ls_req_size), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_rdata(ls_rsp_rdata),
        .ls_rsp_err(ls_rsp_err),
        .ram_wen(ram_wen), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_ren(ram_ren), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    always #5 clk = ~clk;

    // RAM model: preloaded during tb_init, read data appears the cycle after ram_ren
    always_ff @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]     <= 32'hDEADBEEF;
            mem[5]     <= 32'h01020304;
            ram_r_data <= 32'h0;
        end else begin
            if (ram_ren) ram_r_data <= mem[ram_r_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_w_addr[7:2]][8*b +: 8] <= ram_w_data[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ls_drive(input logic v, input logic we, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
        ls_req_valid = v; ls_req_we = we; ls_req_size = sz; ls_req_addr = a; ls_req_wdata = wd;
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        clk = 1'b0; rstn = 1'b1; tb_init = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 32'h0; if_rsp_ready = 1'b1; ls_rsp_ready = 1'b1;
        ls_drive(1'b1, 1'b0, 2'd2, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_if_ready", {31'h0, if_req_ready}, 32'h0);
        chk("rst_ls_ready", {31'h0, ls_req_ready}, 32'h0);
        chk("rst_if_rsp_valid", {31'h0, if_rsp_valid}, 32'h0);
        chk("rst_ls_rsp_valid", {31'h0, ls_rsp_valid}, 32'h0);
        chk("rst_ram_ren", {31'h0, ram_ren}, 32'h0);
        chk("rst_ram_wen", {28'h0, ram_wen}, 32'h0);
        if_req_valid = 1'b0; ls_req_valid = 1'b0; rstn = 1'b0; tb_init = 1'b0;
        @(negedge clk);

        // IF reads, back to back; low address bits ignored
        if_req_valid = 1'b1; if_req_addr = 32'h10; #1;
        chk("if_ready", {31'h0, if_req_ready}, 32'h1);
        chk("if_ram_ren", {31'h0, ram_ren}, 32'h1);
        chk("if_ram_raddr", ram_r_addr, 32'h10);
        @(negedge clk);
        chk("if_rsp_valid", {31'h0, if_rsp_valid}, 32'h1);
        chk("if_rsp_data0", if_rsp_data, 32'hDEADBEEF);
        if_req_addr = 32'h17; #1;
        chk("if_b2b_ready", {31'h0, if_req_ready}, 32'h1);
        chk("if_ram_raddr_align", ram_r_addr, 32'h14);
        @(negedge clk);
        chk("if_rsp_data1", if_rsp_data, 32'h01020304);
        if_req_valid = 1'b0;
        @(negedge clk);
        chk("if_rsp_idle", {31'h0, if_rsp_valid}, 32'h0);

        // Conflicting IF and LS load: IF, LS, IF, LS
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        ls_drive(1'b1, 1'b0, 2'd2, 32'h14, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("arb_if_ready", {31'h0, if_req_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("arb_ls_ready", {31'h0, ls_req_ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
            @(negedge clk);
        end
        chk("arb_ls_rsp_data", ls_rsp_rdata, 32'h01020304);
        chk("arb_if_rsp_valid", {31'h0, if_rsp_valid}, 32'h0);
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        @(negedge clk);

        // Byte store, then word and half loads of the same word
        ls_drive(1'b1, 1'b1, 2'd0, 32'h23, 32'h000000A5); #1;
        chk("st_ready", {31'h0, ls_req_ready}, 32'h1);
        chk("st_wen", {28'h0, ram_wen}, 32'h8);
        chk("st_wdata", ram_w_data, 32'hA5A5A5A5);
        chk("st_waddr", ram_w_addr, 32'h20);
        chk("st_no_ren", {31'h0, ram_ren}, 32'h0);
        @(negedge clk);
        chk("st_rsp_valid", {31'h0, ls_rsp_valid}, 32'h1);
        chk("st_rsp_err", {31'h0, ls_rsp_err}, 32'h0);
        chk("st_rsp_rdata", ls_rsp_rdata, 32'h0);
        ls_drive(1'b1, 1'b0, 2'd2, 32'h20, 32'h0); #1;
        chk("ldw_ren", {31'h0, ram_ren}, 32'h1);
        @(negedge clk);
        chk("ldw_rdata", ls_rsp_rdata, 32'hA5000000);
        ls_drive(1'b1, 1'b0, 2'd1, 32'h22, 32'h0);
        @(negedge clk);
        chk("ldh_rdata", ls_rsp_rdata, 32'h0000A500);

        // Misaligned half, illegal size, misaligned word store
        ls_drive(1'b1, 1'b0, 2'd1, 32'h21, 32'h0); #1;
        chk("mis_ready", {31'h0, ls_req_ready}, 32'h1);
        chk("mis_no_ren", {31'h0, ram_ren}, 32'h0);
        @(negedge clk);
        chk("mis_valid", {31'h0, ls_rsp_valid}, 32'h1);
        chk("mis_err", {31'h0, ls_rsp_err}, 32'h1);
        chk("mis_rdata", ls_rsp_rdata, 32'h0);
        ls_drive(1'b1, 1'b0, 2'd3, 32'h20, 32'h0); #1;
        chk("sz3_no_ren", {31'h0, ram_ren}, 32'h0);
        @(negedge clk);
        chk("sz3_err", {31'h0, ls_rsp_err}, 32'h1);
        chk("sz3_rdata", ls_rsp_rdata, 32'h0);
        ls_drive(1'b1, 1'b1, 2'd2, 32'h22, 32'hFFFFFFFF); #1;
        chk("mis_st_no_wen", {28'h0, ram_wen}, 32'h0);
        @(negedge clk);
        chk("mis_st_err", {31'h0, ls_rsp_err}, 32'h1);
        ls_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

        // IF response held for 3 cycles while LS rewrites the word and reloads elsewhere
        if_req_valid = 1'b1; if_req_addr = 32'h20; if_rsp_ready = 1'b0; #1;
        chk("hold_acc_ready", {31'h0, if_req_ready}, 32'h1);
        @(negedge clk);
        chk("hold_live_valid", {31'h0, if_rsp_valid}, 32'h1);
        chk("hold_live_data", if_rsp_data, 32'hA5000000);
        chk("hold_live_ready", {31'h0, if_req_ready}, 32'h0);
        ls_drive(1'b1, 1'b1, 2'd2, 32'h20, 32'hCAFEF00D); #1;
        chk("hold_st_wen", {28'h0, ram_wen}, 32'hF);
        @(negedge clk);
        chk("hold1_data", if_rsp_data, 32'hA5000000);
        chk("hold1_ready", {31'h0, if_req_ready}, 32'h0);
        ls_drive(1'b1, 1'b0, 2'd2, 32'h10, 32'h0); #1;
        chk("hold_ld_raddr", ram_r_addr, 32'h10);
        @(negedge clk);
        chk("hold2_data", if_rsp_data, 32'hA5000000);
        chk("hold2_valid", {31'h0, if_rsp_valid}, 32'h1);
        chk("hold_ls_rdata", ls_rsp_rdata, 32'hDEADBEEF);
        ls_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        if_rsp_ready = 1'b1; #1;
        chk("drain_ready", {31'h0, if_req_ready}, 32'h1);
        chk("drain_data", if_rsp_data, 32'hA5000000);
        @(negedge clk);
        chk("after_drain_data", if_rsp_data, 32'hCAFEF00D);
        if_req_valid = 1'b0;
        @(negedge clk);

        // Conflict won by IF, then reset discards the response and restores grant to IF
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        ls_drive(1'b1, 1'b0, 2'd2, 32'h14, 32'h0); #1;
        chk("pre_rst_if_ready", {31'h0, if_req_ready}, 32'h1);
        chk("pre_rst_ls_ready", {31'h0, ls_req_ready}, 32'h0);
        @(negedge clk);
        rstn = 1'b1; #1;
        chk("mid_rst_rsp_valid", {31'h0, if_rsp_valid}, 32'h0);
        chk("mid_rst_if_ready", {31'h0, if_req_ready}, 32'h0);
        chk("mid_rst_ram_ren", {31'h0, ram_ren}, 32'h0);
        @(negedge clk);
        rstn = 1'b0; #1;
        chk("post_rst_rsp_valid", {31'h0, if_rsp_valid}, 32'h0);
        chk("post_rst_if_wins", {31'h0, if_req_ready}, 32'h1);
        chk("post_rst_ls_loses", {31'h0, ls_req_ready}, 32'h0);
        @(negedge clk);
        chk("post_rst_if_data", if_rsp_data, 32'hDEADBEEF);
        if_req_valid = 1'b0; ls_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);

        // Same-cycle IF read and LS byte store to one word
        ls_drive(1'b1, 1'b1, 2'd2, 32'h20, 32'h11223344);
        @(negedge clk);
        if_req_valid = 1'b1; if_req_addr = 32'h20;
        ls_drive(1'b1, 1'b1, 2'd0, 32'h20, 32'h0000005A); #1;
        chk("raw_if_ready", {31'h0, if_req_ready}, 32'h1);
        chk("raw_ls_ready", {31'h0, ls_req_ready}, 32'h1);
        chk("raw_wen", {28'h0, ram_wen}, 32'h1);
        @(negedge clk);
`ifdef RAM_RAW_BYPASS_EN
        exp_byp = 32'h1122335A;
`else
        exp_byp = 32'h11223344;
`endif
        chk("raw_if_data", if_rsp_data, exp_byp);
        ls_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("raw_reread", if_rsp_data, 32'h1122335A);
        if_req_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the byte-lane data RAM between the instruction-fetch port (IF, read-only) and the load/store port (LS, read/write).
- Arbitrates the single RAM read port round-robin.
- For LS, generates the byte write enables and lane-replicated store data, right-aligns load data and flags misaligned accesses.
- Sits between the core pipeline and the RAM; all RAM pins drive the RAM directly.

Parameters:
DW, 32, data width; the block supports 32 only
AW, 32, byte address width

Ports:
clk  input  1  clock; all logic on posedge
rstn  input  1  reset, synchronous, active-high (1 = reset)
if_req_valid  input  1  IF read request
if_req_ready  output  1  IF request accepted this cycle
if_req_addr  input  AW  IF byte address; bits [1:0] are ignored
if_rsp_valid  output  1  IF read data valid
if_rsp_ready  input  1  IF consumer accepts response
if_rsp_data  output  DW  IF read word
ls_req_valid  input  1  LS request
ls_req_ready  output  1  LS request accepted this cycle
ls_req_we  input  1  1 = store, 0 = load
ls_req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
ls_req_addr  input  AW  LS byte address
ls_req_wdata  input  DW  store data, right-aligned
ls_rsp_valid  output  1  LS response valid
ls_rsp_ready  input  1  LS consumer accepts response
ls_rsp_rdata  output  DW  load data, right-aligned and zero-extended; 0 for stores and errors
ls_rsp_err  output  1  misaligned or illegal-size access
ram_wen  output  4  byte write enables
ram_w_addr  output  AW  RAM write address, bits [1:0] = 0
ram_w_data  output  DW  lane-replicated store data
ram_ren  output  1  RAM read enable
ram_r_addr  output  AW  RAM read address, bits [1:0] = 0
ram_r_data  input  DW  RAM read data; valid the cycle after ram_ren

Behaviour:
- Handshake: a transfer occurs when valid && ready, on either request or response. Each port has at most one outstanding request.
- Response slot per port has three states:
  - EMPTY: nothing outstanding.
  - LIVE: the cycle after acceptance; read data is taken combinationally from ram_r_data.
  - HOLD: response not accepted while LIVE; data is captured into a register and presented until accepted.
- Slot transitions: accept -> LIVE; LIVE & rsp_ready -> EMPTY (or LIVE again if a new request is accepted in the same cycle); LIVE & !rsp_ready -> HOLD; HOLD & rsp_ready -> EMPTY (or LIVE). Response latency is 1 cycle.
- A port is eligible when req_valid && (slot EMPTY || slot draining this cycle).
- Read-port arbitration applies only when IF and an LS load are both eligible:
  - Round-robin; the loser's req_ready = 0.
  - last_grant resets to LS, so IF wins the first conflict.
  - last_grant updates only on a conflicting grant.
- LS stores and error requests never use the read port and never conflict with IF; ready = eligibility.
- Store encoding:
  - byte: ram_wen = 4'b0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - half: ram_wen = 4'b0011 << {addr[1],1'b0}; data = {2{wdata[15:0]}}.
  - word: ram_wen = 4'hF; data = wdata.
  - The write occurs in the accept cycle. The response follows next cycle with err = 0 and rdata = 0.
- Load: the accepted word is shifted right by addr[1:0]*8, then masked to 8/16/32 bits. Addr[1:0] and size are registered at accept time.
- Misalignment (half with addr[0] = 1, word with addr[1:0] != 0, size = 3): request accepted, no RAM access (ram_wen = 0, no ram_ren); response next cycle with err = 1, rdata = 0.
- When idle: ram_wen = 0, ram_ren = 0; address and data outputs are don't-care but driven to 0.
- Reset (any cycle, including mid-transfer): all slots go EMPTY; all valid and ready outputs, ram_wen and ram_ren = 0; last_grant = LS; in-flight responses are discarded. ready outputs are 0 during reset.

Optional Feature:
RAM_RAW_BYPASS_EN
- When a store and a load to the same word are accepted in the same cycle, the RAM returns the pre-write word.
- Defined: the controller registers ram_wen and ram_w_data at acceptance and merges the written bytes into the returned word before alignment (read-after-write coherent).
- Undefined: the returned word is the pre-write RAM contents.
- Only an IF read can coincide with an LS store, so the merge applies to the IF response.

Test Plan:
- IF reads 0x10 holding 0xDEADBEEF, rsp_ready = 1 -> if_rsp_valid in the next cycle, data 0xDEADBEEF; back-to-back reads sustain 1 per cycle.
- IF and LS load both valid for 4 cycles -> grants IF, LS, IF, LS; the loser sees req_ready = 0 that cycle.
- LS byte store 0xA5 to 0x23, then word load 0x20 (previous contents 0) -> ram_wen = 4'b1000, ram_w_data = 0xA5A5A5A5; load returns 0xA5000000.
- LS half load at 0x21 -> err = 1, rdata = 0, no ram_ren; size = 3 behaves the same.
- IF rsp_ready held 0 for 3 cycles while LS writes the same word -> if_rsp_data stays at the captured value; next IF request is not accepted until the response drains.
- rstn = 1 in the cycle after acceptance -> no rsp_valid appears; the first post-reset conflict is granted to IF.
- With RAM_RAW_BYPASS_EN, same-cycle IF read of 0x20 and LS byte store 0x5A to 0x20 (old 0x11223344) -> IF data 0x1122335A; without the macro -> 0x11223344.
